moore_control: RTL and testbench



---
 rtl/moore_control_pkg.sv | 16 +
 rtl/sync_chain.sv | 34 +++
 rtl/moore_control.sv | 106 ++++++++++
 tb/tb_moore_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/moore_control_pkg.sv
// Shared types and default constants for the alternating two-actuator controller.
package moore_control_pkg;

    // 3-bit binary state encoding; codes 5..7 are unused and treated as FAULT.
    typedef enum logic [2:0] {
        IDLE0 = 3'd0,
        RUN0  = 3'd1,
        IDLE1 = 3'd2,
        RUN1  = 3'd3,
        FAULT = 3'd4
    } stateT;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int MIN_RUN_DEF     = 4;

endpackage

// File: rtl/sync_chain.sv
// Parameterised-depth 1-bit synchroniser, cleared to 0 on reset.
// Depth 0 passes the input straight through.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : gBypass
            assign q = d;
        end else begin : gChain
            logic [STAGES-1:0] ff;

            // Shift the input through STAGES flops; ff[0] is nearest the pin.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ff <= '0;
                end else begin
                    ff[0] <= d;
                    for (int k = 1; k < STAGES; k++) begin
                        ff[k] <= ff[k-1];
                    end
                end
            end

            assign q = ff[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/moore_control.sv
// Moore controller alternating two actuators: each start request energises the
// next actuator in turn until the stop condition, with a guaranteed minimum run.
//
// state | meaning
// IDLE0 | waiting for start, next run uses B0
// RUN0  | B0 energised
// IDLE1 | waiting for start, next run uses B1
// RUN1  | B1 energised
// FAULT | start and stop seen together; outputs off until reset
module moore_control
    import moore_control_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int MIN_RUN     = MIN_RUN_DEF
) (
    input  logic inputI,
    input  logic inputS,
    input  logic inputClk,
    input  logic inputReset,
    output logic outputB0,
    output logic outputB1
);

    localparam int CNT_W = (MIN_RUN > 1) ? $clog2(MIN_RUN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_RUN - 1);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] runCnt;
    logic [CNT_W-1:0] runCntNext;
    logic             iSync;
    logic             sSync;
    logic             minDone;

    sync_chain #(.STAGES(SYNC_STAGES)) uSyncI (
        .clk (inputClk),
        .rst (inputReset),
        .d   (inputI),
        .q   (iSync)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) uSyncS (
        .clk (inputClk),
        .rst (inputReset),
        .d   (inputS),
        .q   (sSync)
    );

    // Counter saturates, so reaching the limit is a simple compare.
    assign minDone = (runCnt >= CNT_MAX);

    // State and run-counter registers.
    always_ff @(posedge inputClk or posedge inputReset) begin
        if (inputReset) begin
            state  <= IDLE0;
            runCnt <= '0;
        end else begin
            state  <= stateNext;
            runCnt <= runCntNext;
        end
    end

    // Next-state and counter update; inconsistent sensors override everything.
    always_comb begin
        stateNext  = state;
        runCntNext = runCnt;
        if (state != FAULT && iSync && sSync) begin
            stateNext = FAULT;
        end else begin
            case (state)
                IDLE0: begin
                    if (iSync) begin
                        stateNext  = RUN0;
                        runCntNext = '0;
                    end
                end
                IDLE1: begin
                    if (iSync) begin
                        stateNext  = RUN1;
                        runCntNext = '0;
                    end
                end
                RUN0: begin
                    if (sSync && minDone) begin
                        stateNext = IDLE1;
                    end else if (!minDone) begin
                        runCntNext = runCnt + 1'b1;
                    end
                end
                RUN1: begin
                    if (sSync && minDone) begin
                        stateNext = IDLE0;
                    end else if (!minDone) begin
                        runCntNext = runCnt + 1'b1;
                    end
                end
                FAULT:   stateNext = FAULT;
                default: stateNext = FAULT;
            endcase
        end
    end

    assign outputB0 = (state == RUN0);
    assign outputB1 = (state == RUN1);

endmodule

// File: tb/tb_moore_control.sv
// Bench for moore_control: one DUT with default synchroniser depth and one in
// bypass, driven by the same inputs and checked against a reference model.

// Free-running bench clock, period 10, starting low.
module clock_gen (
    output logic clk
);
    initial clk = 1'b0;
    always #5 clk = ~clk;
endmodule

module tb_moore_control;
    import moore_control_pkg::*;

    localparam int MINRUN = 4;

    logic clk;
    logic rst;
    logic iIn;
    logic sIn;
    logic b0Sync, b1Sync, b0Byp, b1Byp;

    int compared   = 0;
    int mismatched = 0;

    // Expected {B1,B0} of bypass DUT in [3:2], of synchronised DUT in [1:0].
    logic [3:0] expQ[$];
    // History of {I,S} sampled at each edge, newest at the back.
    logic [1:0] hist[$];

    // Model: per DUT, whether faulted, whether running, which actuator, cycles run.
    bit mFault[2];
    bit mRun[2];
    bit mWhich[2];
    int mCycles[2];
    int depthOf[2] = '{2, 0};

    clock_gen uClk (.clk(clk));

    moore_control #(.SYNC_STAGES(2), .MIN_RUN(MINRUN)) dutSync (
        .inputI     (iIn),
        .inputS     (sIn),
        .inputClk   (clk),
        .inputReset (rst),
        .outputB0   (b0Sync),
        .outputB1   (b1Sync)
    );

    moore_control #(.SYNC_STAGES(0), .MIN_RUN(MINRUN)) dutByp (
        .inputI     (iIn),
        .inputS     (sIn),
        .inputClk   (clk),
        .inputReset (rst),
        .outputB0   (b0Byp),
        .outputB1   (b1Byp)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got B1B0=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        repeat (3) hist.push_back(2'b00);
        expQ.delete();
        for (int d = 0; d < 2; d++) begin
            mFault[d]  = 1'b0;
            mRun[d]    = 1'b0;
            mWhich[d]  = 1'b0;
            mCycles[d] = 0;
        end
    endtask

    // Reference model: one step per rising edge, pushes the outputs expected after it.
    always @(posedge clk) begin : modelStep
        logic [1:0] seen;
        logic [3:0] e;
        if (!rst) begin
            hist.push_back({iIn, sIn});
            if (hist.size() > 8) void'(hist.pop_front());
            e = '0;
            for (int d = 0; d < 2; d++) begin
                seen = hist[hist.size() - 1 - depthOf[d]];
                if (mFault[d]) begin
                    // stuck until reset
                end else if (seen[1] && seen[0]) begin
                    mFault[d] = 1'b1;
                    mRun[d]   = 1'b0;
                end else if (!mRun[d]) begin
                    if (seen[1]) begin
                        mRun[d]    = 1'b1;
                        mCycles[d] = 0;
                    end
                end else begin
                    if (seen[0] && mCycles[d] >= MINRUN - 1) begin
                        mRun[d]   = 1'b0;
                        mWhich[d] = ~mWhich[d];
                    end else begin
                        mCycles[d]++;
                    end
                end
                e[2*d]   = mRun[d] && (mWhich[d] == 1'b0);
                e[2*d+1] = mRun[d] && (mWhich[d] == 1'b1);
            end
            expQ.push_back(e);
        end
    end

    // Monitor: the outputs are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (!rst && expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("scoreboard_sync", {b1Sync, b0Sync}, e[1:0]);
            chk("scoreboard_bypass", {b1Byp, b0Byp}, e[3:2]);
        end
    end

    // Each drive step starts and ends 2 time units after a rising edge.
    task automatic drive(input logic i, input logic s, input int n);
        iIn = i;
        sIn = s;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        iIn = 1'b0;
        sIn = 1'b0;
        expQ.delete();
        repeat (2) @(posedge clk);
        #2;
        modelReset();
        rst = 1'b0;
    endtask

    initial begin : stimulus
        int runLen;
        int r;
        rst = 1'b1;
        iIn = 1'b0;
        sIn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("reset_idle_sync", {b1Sync, b0Sync}, 2'b00);
        chk("reset_idle_bypass", {b1Byp, b0Byp}, 2'b00);

        // Basic run: B0 rises two edges after the request is sampled.
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1);
        chk("basic_latency_lo", {b1Sync, b0Sync}, 2'b00);
        drive(1'b0, 1'b0, 1);
        chk("basic_start", {b1Sync, b0Sync}, 2'b01);
        drive(1'b0, 1'b0, 7);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        chk("basic_stop_pending", {b1Sync, b0Sync}, 2'b01);
        drive(1'b0, 1'b0, 4);
        chk("basic_stopped", {b1Sync, b0Sync}, 2'b00);

        // Alternation: B1, then B0 again.
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 6);
        chk("alt_b1_run", {b1Sync, b0Sync}, 2'b10);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 5);
        chk("alt_b1_stop", {b1Sync, b0Sync}, 2'b00);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 6);
        chk("alt_b0_again", {b1Sync, b0Sync}, 2'b01);
        drive(1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 4);

        // S while idle with I low is ignored.
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 4);
        chk("idle_stop_ignored", {b1Sync, b0Sync}, 2'b00);

        // Asynchronous reset in the middle of a RUN0.
        doReset();
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 4);
        chk("pre_reset_run0", {b1Sync, b0Sync}, 2'b01);
        rst = 1'b1;
        expQ.delete();
        #1;
        chk("async_reset_sync", {b1Sync, b0Sync}, 2'b00);
        chk("async_reset_bypass", {b1Byp, b0Byp}, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        modelReset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5);
        chk("post_reset_quiet", {b1Sync, b0Sync}, 2'b00);

        // Minimum run: stop held from the cycle after the request.
        drive(1'b1, 1'b0, 1);
        iIn    = 1'b0;
        sIn    = 1'b1;
        runLen = 0;
        repeat (14) begin
            @(negedge clk);
            if (b0Sync) runLen++;
        end
        chkInt("min_run_len", runLen, MINRUN);
        @(posedge clk);
        #2;
        drive(1'b0, 1'b0, 4);

        // Fault during RUN0, sticky until reset.
        doReset();
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b1, 1);
        drive(1'b0, 1'b0, 1);
        chk("fault_latency_lo", {b1Sync, b0Sync}, 2'b01);
        drive(1'b0, 1'b0, 1);
        chk("fault_outputs", {b1Sync, b0Sync}, 2'b00);
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 3);
        chk("fault_sticky", {b1Sync, b0Sync}, 2'b00);
        doReset();
        drive(1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 2);
        chk("post_fault_run", {b1Sync, b0Sync}, 2'b01);
        drive(1'b0, 1'b1, 5);
        drive(1'b0, 1'b0, 3);

        // Bypass: request before an edge shows up right after that edge.
        doReset();
        iIn = 1'b1;
        @(posedge clk);
        #1;
        chk("bypass_edge", {b1Byp, b0Byp}, 2'b01);
        chk("sync_not_yet", {b1Sync, b0Sync}, 2'b00);
        #1;
        iIn = 1'b0;
        drive(1'b0, 1'b0, 6);

        // Randomised segments, each from reset.
        for (int seg = 0; seg < 6; seg++) begin
            doReset();
            for (int c = 0; c < 150; c++) begin
                r = $urandom_range(0, 99);
                drive(r < 15, (r >= 12) && (r < 45), 1);
            end
        end

        drive(1'b0, 1'b0, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
